z80_mem_bridge: RTL and testbench

- Bus-side initiator for the on-chip 1 KiB synchronous RAM (registered read, write-enable port, one clock).
- Converts asynchronous Z80 memory cycles (MREQ/RD/WR, 16-bit address, 8-bit data) into single-clock RAM accesses.
- Stretches the Z80 cycle with WAIT_n until read data is captured or the write is committed.
- Sits between the Z80 core pins and the RAM instance.

---
 rtl/z80_mem_bridge_pkg.sv | 14 +
 rtl/z80_mem_bridge_sync_bit.sv | 23 ++
 rtl/z80_mem_bridge.sv | 155 +++++++++++++++
 tb/tb_z80_mem_bridge.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/z80_mem_bridge_pkg.sv
// Shared definitions for the Z80-to-RAM bridge: FSM encoding and the RAM geometry.
package z80_mem_bridge_pkg;

  localparam int unsigned RAM_ADDR_W = 10;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRdAddr   = 3'd1,
    StRdData   = 3'd2,
    StWrCommit = 3'd3,
    StDone     = 3'd4
  } state_e;

endpackage

// File: rtl/z80_mem_bridge_sync_bit.sv
// Single-bit multi-flop synchronizer; resets to 1 so inactive-high strobes read idle.
module sync_bit #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/z80_mem_bridge.sv
// Turns asynchronous Z80 memory cycles into single-clock accesses on a registered-read RAM,
// holding the CPU off with WAIT_n until the read data is presented or the write is committed.
module z80_mem_bridge
  import z80_mem_bridge_pkg::*;
#(
  parameter int unsigned AddrW      = RAM_ADDR_W,
  parameter logic [15:0] Base       = 16'h0000,
  parameter int unsigned SyncStages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [15:0]      z_addr_i,
  input  logic [7:0]       z_data_in_i,
  output logic [7:0]       z_data_out_o,
  output logic             z_data_oe_o,
  input  logic             z_mreq_n_i,
  input  logic             z_rd_n_i,
  input  logic             z_wr_n_i,
  output logic             z_wait_n_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [7:0]       mem_wdata_o,
  output logic             mem_we_o,
  input  logic [7:0]       mem_rdata_i
);

  logic mreq_s, rd_s, wr_s;
  logic hit, sel, done_exit;

  state_e           state_q, state_d;
  logic [AddrW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             mem_we_q, mem_we_d;
  logic [7:0]       z_data_out_q, z_data_out_d;
  logic             z_data_oe_q, z_data_oe_d;
  logic             z_wait_n_q, z_wait_n_d;

  sync_bit #(.Stages(SyncStages)) u_sync_mreq (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (z_mreq_n_i),
    .q_o    (mreq_s)
  );

  sync_bit #(.Stages(SyncStages)) u_sync_rd (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (z_rd_n_i),
    .q_o    (rd_s)
  );

  sync_bit #(.Stages(SyncStages)) u_sync_wr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (z_wr_n_i),
    .q_o    (wr_s)
  );

  assign hit       = (z_addr_i[15:AddrW] == Base[15-AddrW:0]);
  assign sel       = ~mreq_s & hit;
  // Leave DONE only once the CPU has dropped the cycle, so a held strobe cannot retrigger.
  assign done_exit = mreq_s | (rd_s & wr_s);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (sel && !rd_s) begin
          state_d = StRdAddr;
        end else if (sel && !wr_s) begin
          state_d = StWrCommit;
        end
      end
      StRdAddr:   state_d = StRdData;
      StRdData:   state_d = StDone;
      StWrCommit: state_d = StDone;
      StDone: begin
        if (done_exit) begin
          state_d = StIdle;
        end
      end
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    z_data_out_d = z_data_out_q;
    z_data_oe_d  = z_data_oe_q;
    z_wait_n_d   = z_wait_n_q;
    unique case (state_q)
      StIdle: begin
        if (sel && !rd_s) begin
          mem_addr_d = z_addr_i[AddrW-1:0];
          z_wait_n_d = 1'b0;
        end else if (sel && !wr_s) begin
          mem_addr_d  = z_addr_i[AddrW-1:0];
          mem_wdata_d = z_data_in_i;
          mem_we_d    = 1'b1;
          z_wait_n_d  = 1'b0;
        end
      end
      StRdData: begin
        z_data_out_d = mem_rdata_i;
        z_data_oe_d  = 1'b1;
        z_wait_n_d   = 1'b1;
      end
      StWrCommit: begin
        mem_we_d   = 1'b0;
        z_wait_n_d = 1'b1;
      end
      StDone: begin
        if (done_exit) begin
          z_data_oe_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      z_data_out_q <= '0;
      z_data_oe_q  <= 1'b0;
      z_wait_n_q   <= 1'b1;
    end else begin
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      z_data_out_q <= z_data_out_d;
      z_data_oe_q  <= z_data_oe_d;
      z_wait_n_q   <= z_wait_n_d;
    end
  end

  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_we_o     = mem_we_q;
  assign z_data_out_o = z_data_out_q;
  assign z_data_oe_o  = z_data_oe_q;
  assign z_wait_n_o   = z_wait_n_q;

endmodule

// File: tb/tb_z80_mem_bridge.sv
// Directed plus randomized Z80 memory cycles against a byte-array model of the RAM contents.
module tb_z80_mem_bridge;
  import z80_mem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] z_addr;
  logic [7:0]  z_data_in;
  logic [7:0]  z_data_out;
  logic        z_data_oe;
  logic        z_mreq_n, z_rd_n, z_wr_n;
  logic        z_wait_n;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation accumulators for one access
  int         wait_lo, we_cnt;
  logic       oe_seen, data_moved;
  logic [7:0] rd_data, we_data;
  logic [9:0] we_addr;

  logic [7:0] ram [1024];
  bit         written [1024];
  logic [7:0] ref_mem [1024];

  z80_mem_bridge dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .z_addr_i     (z_addr),
    .z_data_in_i  (z_data_in),
    .z_data_out_o (z_data_out),
    .z_data_oe_o  (z_data_oe),
    .z_mreq_n_i   (z_mreq_n),
    .z_rd_n_i     (z_rd_n),
    .z_wr_n_i     (z_wr_n),
    .z_wait_n_o   (z_wait_n),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_we_o     (mem_we),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [9:0] a);
    return (a == 10'h005) ? 8'hA7 : (a[7:0] ^ 8'h5A);
  endfunction

  // Synchronous RAM with registered read
  always_ff @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    mem_rdata <= written[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    wait_lo = 0; we_cnt = 0; oe_seen = 1'b0; data_moved = 1'b0;
    rd_data = '0; we_data = '0; we_addr = '0;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (z_wait_n === 1'b0) wait_lo++;
      if (mem_we === 1'b1) begin
        we_cnt++;
        we_addr = mem_addr;
        we_data = mem_wdata;
      end
      if (z_data_oe === 1'b1) begin
        if (!oe_seen) begin
          oe_seen = 1'b1;
          rd_data = z_data_out;
        end else if (z_data_out !== rd_data) begin
          data_moved = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input bit rd, input bit wr);
    @(negedge clk);
    z_addr    = a;
    z_data_in = d;
    z_mreq_n  = 1'b0;
    z_rd_n    = ~rd;
    z_wr_n    = ~wr;
  endtask

  task automatic release_bus(input int n);
    @(negedge clk);
    z_mreq_n = 1'b1;
    z_rd_n   = 1'b1;
    z_wr_n   = 1'b1;
    observe(n);
  endtask

  task automatic expect_access(input logic [15:0] a, input logic [7:0] d, input bit rd,
                               input bit wr);
    bit hit, is_rd, is_wr;
    hit   = (a[15:10] == 6'h00);
    is_rd = hit && rd;
    is_wr = hit && wr && !rd;
    check("wait_low_cycles", 32'(wait_lo), is_rd ? 32'd2 : (is_wr ? 32'd1 : 32'd0));
    check("we_pulses", 32'(we_cnt), is_wr ? 32'd1 : 32'd0);
    check("oe_seen", 32'(oe_seen), 32'(is_rd));
    if (is_wr) begin
      check("we_addr", 32'(we_addr), 32'(a[9:0]));
      check("we_data", 32'(we_data), 32'(d));
      ref_mem[a[9:0]] = d;
    end
    if (is_rd) begin
      check("rd_data", 32'(rd_data), 32'(ref_mem[a[9:0]]));
      check("rd_data_held", 32'(data_moved), 32'd0);
    end
    check("oe_after_release", 32'(z_data_oe), 32'd0);
    check("wait_after_release", 32'(z_wait_n), 32'd1);
  endtask

  task automatic access(input logic [15:0] a, input logic [7:0] d, input bit rd, input bit wr,
                        input int hold);
    clear_obs();
    drive(a, d, rd, wr);
    observe(hold);
    release_bus(3);
    expect_access(a, d, rd, wr);
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rd8;
    int          op;
    bit          found;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(10'(i));
    rst_n = 1'b0; z_addr = '0; z_data_in = '0;
    z_mreq_n = 1'b1; z_rd_n = 1'b1; z_wr_n = 1'b1;

    // Reset held while the strobes toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      z_mreq_n = i[0]; z_rd_n = i[0]; z_wr_n = ~i[0]; z_addr = 16'h0005;
    end
    check("rst_wait_n", 32'(z_wait_n), 32'd1);
    check("rst_oe", 32'(z_data_oe), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_data_out", 32'(z_data_out), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    z_mreq_n = 1'b1; z_rd_n = 1'b1; z_wr_n = 1'b1;
    rst_n = 1'b1;
    observe(3);

    // Preloaded read
    access(16'h0005, 8'h00, 1'b1, 1'b0, 10);
    check("read_0005_value", 32'(rd_data), 32'h0000_00A7);

    // Write to the top address, then read it back
    access(16'h03FF, 8'h3C, 1'b0, 1'b1, 10);
    access(16'h03FF, 8'h00, 1'b1, 1'b0, 10);
    check("readback_03ff", 32'(rd_data), 32'h0000_003C);

    // Out of range
    access(16'h0400, 8'h55, 1'b1, 1'b0, 10);
    check("oor_state_idle", 32'(dut.state_q), 32'(StIdle));
    access(16'h0400, 8'h55, 1'b0, 1'b1, 10);

    // Read and write strobes together: the read wins
    access(16'h0005, 8'hEE, 1'b1, 1'b1, 10);

    // Reset asserted while in RD_ADDR
    clear_obs();
    drive(16'h0005, 8'h00, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (dut.state_q == StRdAddr) found = 1'b1;
    end
    check("reach_rd_addr", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_wait_n", 32'(z_wait_n), 32'd1);
    check("midrst_oe", 32'(z_data_oe), 32'd0);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    observe(12);
    release_bus(3);
    expect_access(16'h0005, 8'h00, 1'b1, 1'b0);

    // Strobes held for 20 clocks, then an immediate write
    access(16'h0123, 8'h00, 1'b1, 1'b0, 20);
    access(16'h0124, 8'h9D, 1'b0, 1'b1, 20);
    access(16'h0124, 8'h00, 1'b1, 1'b0, 8);

    // Randomized mix of reads, writes, overlapping strobes and out-of-range cycles
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) ra = {6'($urandom_range(1, 63)), 10'($urandom)};
      else ra = {6'h00, 10'($urandom)};
      rd8 = 8'($urandom);
      op  = int'($urandom_range(0, 2));
      access(ra, rd8, op != 1, op != 0, int'($urandom_range(8, 20)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
